// File: rtl/ascon_permutation_engine.sv
// rtl/ascon_permutation_engine.sv - self-sequencing Ascon permutation with entry/exit XORs
// State layout is {x0,x1,x2,x3,x4}, x0 in the top 64 bits.
module ascon_permutation_engine #(
    parameter int UNROLL = 1,
    parameter int RATE   = 64
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            i_sys_enable,
    input  logic            i_start,
    input  logic [3:0]      i_num_rounds,
    input  logic            i_enable_xor_key_begin,
    input  logic            i_enable_xor_data_begin,
    input  logic            i_enable_xor_key_end,
    input  logic            i_enable_xor_lsb_end,
    input  logic [319:0]    i_state,
    input  logic [RATE-1:0] i_data,
    input  logic [127:0]    i_key,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_error,
    output logic [319:0]    o_state,
    output logic [RATE-1:0] o_cipher,
    output logic [127:0]    o_tag
);

    generate
        if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
            $error("ascon_permutation_engine: UNROLL must be 1 or 2");
        end
        if (RATE != 64 && RATE != 128) begin : g_bad_rate
            $error("ascon_permutation_engine: RATE must be 64 or 128");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} t_fsm;

    t_fsm          fsm;
    t_fsm          fsm_next;
    logic [319:0]  state_reg;
    logic [3:0]    rc_idx;
    logic [127:0]  key_q;
    logic          key_end_q;
    logic          lsb_end_q;
    logic [319:0]  entry_value;
    logic [319:0]  round_out;
    logic [319:0]  exit_value;
    logic          rounds_legal;
    logic          last_step;

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] sbox_layer(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] linear_layer(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4;
        {x0, x1, x2, x3, x4} = s;
        x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Round constant lands in the low byte of x2 (bits 135:128 of the flat state).
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [319:0] t;
        t = s;
        t[135:128] = t[135:128] ^ {4'hF - r, r};
        return linear_layer(sbox_layer(t));
    endfunction

    assign rounds_legal = (i_num_rounds == 4'd6) || (i_num_rounds == 4'd8) ||
                          (i_num_rounds == 4'd12);
    assign last_step    = (rc_idx + 4'(UNROLL)) == 4'd12;

    always_comb begin
        entry_value = i_state;
        if (i_enable_xor_data_begin)
            entry_value[319 -: RATE] = entry_value[319 -: RATE] ^ i_data;
        if (i_enable_xor_key_begin)
            entry_value[319-RATE -: 128] = entry_value[319-RATE -: 128] ^ i_key;
    end

    always_comb begin
        round_out = state_reg;
        for (int u = 0; u < UNROLL; u++)
            round_out = ascon_round(round_out, rc_idx + 4'(u));
    end

    always_comb begin
        exit_value = round_out;
        if (key_end_q)
            exit_value[127:0] = exit_value[127:0] ^ key_q;
        if (lsb_end_q)
            exit_value[0] = ~exit_value[0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            fsm <= IDLE;
        else if (i_sys_enable)
            fsm <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE: if (i_start && rounds_legal) fsm_next = RUN;
            RUN:  if (last_step) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (fsm == RUN);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= '0;
            rc_idx    <= '0;
            key_q     <= '0;
            key_end_q <= 1'b0;
            lsb_end_q <= 1'b0;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
            o_cipher  <= '0;
            o_tag     <= '0;
        end else if (i_sys_enable) begin
            o_done  <= 1'b0;
            o_error <= 1'b0;
            if (fsm == IDLE) begin
                if (i_start && rounds_legal) begin
                    key_q     <= i_key;
                    key_end_q <= i_enable_xor_key_end;
                    lsb_end_q <= i_enable_xor_lsb_end;
                    state_reg <= entry_value;
                    o_cipher  <= entry_value[319 -: RATE];
                    rc_idx    <= 4'd12 - i_num_rounds;
                end else if (i_start) begin
                    o_error <= 1'b1;
                end
            end else begin
                rc_idx <= rc_idx + 4'(UNROLL);
                if (last_step) begin
                    state_reg <= exit_value;
                    o_tag     <= exit_value[127:0];
                    o_done    <= 1'b1;
                end else begin
                    state_reg <= round_out;
                end
            end
        end
    end

    assign o_state = state_reg;

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// tb/tb_ascon_permutation_engine.sv - directed checks against a table-driven Ascon model
module tb_ascon_permutation_engine;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          sys_enable;
    logic [2:0]    start;
    logic [3:0]    num_rounds;
    logic          key_begin, data_begin, key_end, lsb_end;
    logic [319:0]  state_in;
    logic [63:0]   data64;
    logic [127:0]  data128;
    logic [127:0]  key;

    logic [2:0]    busy, done, err;
    logic [319:0]  st0, st1, st2;
    logic [127:0]  tag0, tag1, tag2;
    logic [63:0]   cip0, cip1;
    logic [127:0]  cip2;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    ascon_permutation_engine #(.UNROLL(1), .RATE(64)) u_u1_r64 (
        .clock(clock), .reset_n(reset_n), .i_sys_enable(sys_enable), .i_start(start[0]),
        .i_num_rounds(num_rounds), .i_enable_xor_key_begin(key_begin),
        .i_enable_xor_data_begin(data_begin), .i_enable_xor_key_end(key_end),
        .i_enable_xor_lsb_end(lsb_end), .i_state(state_in), .i_data(data64), .i_key(key),
        .o_busy(busy[0]), .o_done(done[0]), .o_error(err[0]), .o_state(st0),
        .o_cipher(cip0), .o_tag(tag0));

    ascon_permutation_engine #(.UNROLL(2), .RATE(64)) u_u2_r64 (
        .clock(clock), .reset_n(reset_n), .i_sys_enable(sys_enable), .i_start(start[1]),
        .i_num_rounds(num_rounds), .i_enable_xor_key_begin(key_begin),
        .i_enable_xor_data_begin(data_begin), .i_enable_xor_key_end(key_end),
        .i_enable_xor_lsb_end(lsb_end), .i_state(state_in), .i_data(data64), .i_key(key),
        .o_busy(busy[1]), .o_done(done[1]), .o_error(err[1]), .o_state(st1),
        .o_cipher(cip1), .o_tag(tag1));

    ascon_permutation_engine #(.UNROLL(2), .RATE(128)) u_u2_r128 (
        .clock(clock), .reset_n(reset_n), .i_sys_enable(sys_enable), .i_start(start[2]),
        .i_num_rounds(num_rounds), .i_enable_xor_key_begin(key_begin),
        .i_enable_xor_data_begin(data_begin), .i_enable_xor_key_end(key_end),
        .i_enable_xor_lsb_end(lsb_end), .i_state(state_in), .i_data(data128), .i_key(key),
        .o_busy(busy[2]), .o_done(done[2]), .o_error(err[2]), .o_state(st2),
        .o_cipher(cip2), .o_tag(tag2));

    localparam logic [4:0] SBOX [0:31] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    localparam logic [127:0] K_VEC  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] N_VEC  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [63:0]  IV_128  = 64'h80400C0600000000;
    localparam logic [63:0]  IV_128A = 64'h80800C0800000000;

    task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] m_ror(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    // Slice-by-slice S-box lookup, independent of the bitsliced form.
    function automatic logic [319:0] m_round(input logic [319:0] s, input int r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  a, b;
        logic [7:0]  c;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        c = 8'(((15 - r) << 4) | r);
        x[2][7:0] = x[2][7:0] ^ c;
        for (int j = 0; j < 64; j++) begin
            a = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
            b = SBOX[a];
            y[0][j] = b[4]; y[1][j] = b[3]; y[2][j] = b[2]; y[3][j] = b[1]; y[4][j] = b[0];
        end
        x[0] = y[0] ^ m_ror(y[0], 19) ^ m_ror(y[0], 28);
        x[1] = y[1] ^ m_ror(y[1], 61) ^ m_ror(y[1], 39);
        x[2] = y[2] ^ m_ror(y[2], 1)  ^ m_ror(y[2], 6);
        x[3] = y[3] ^ m_ror(y[3], 10) ^ m_ror(y[3], 17);
        x[4] = y[4] ^ m_ror(y[4], 7)  ^ m_ror(y[4], 41);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] m_perm(input logic [319:0] s, input int n);
        logic [319:0] t;
        t = s;
        for (int r = 12 - n; r < 12; r++) t = m_round(t, r);
        return t;
    endfunction

    function automatic logic get_done(input int idx);
        return done[idx];
    endfunction

    function automatic logic get_busy(input int idx);
        return busy[idx];
    endfunction

    task automatic run_op(input int idx, input int n, input int stall_at, input int restart_at,
                          output int lat, output int busy_cnt);
        @(negedge clock);
        num_rounds = 4'(n);
        start[idx] = 1'b1;
        lat = 0;
        busy_cnt = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clock);
            if (j == 1) begin
                start[idx] = 1'b0;
                data64   = ~data64;
                data128  = ~data128;
                key      = ~key;
                state_in = ~state_in;
            end
            if (get_done(idx)) begin
                lat = j;
                break;
            end
            if (get_busy(idx)) busy_cnt++;
            if (j == stall_at) sys_enable = 1'b0;
            if (j == stall_at + 3) sys_enable = 1'b1;
            if (j == restart_at) start[idx] = 1'b1;
            if (j == restart_at + 1) start[idx] = 1'b0;
        end
        sys_enable = 1'b1;
        start[idx] = 1'b0;
    endtask

    logic [319:0] init128, after_init, entry3, want3, entry4, want4, want6;
    int lat, bcnt, done_seen;

    initial begin
        reset_n = 1'b0; sys_enable = 1'b1; start = '0; num_rounds = '0;
        key_begin = 0; data_begin = 0; key_end = 0; lsb_end = 0;
        state_in = '0; data64 = '0; data128 = '0; key = '0;
        repeat (2) @(negedge clock);
        check_eq("reset_state", st0, 320'd0);
        check_eq("reset_tag", tag0, 320'd0);
        check_eq("reset_flags", {busy, done, err}, 320'd0);
        reset_n = 1'b1;

        // Ascon-128 initialisation, UNROLL=1
        init128 = {IV_128, K_VEC, N_VEC};
        after_init = m_perm(init128, 12);
        after_init[127:0] = after_init[127:0] ^ K_VEC;
        state_in = init128; key = K_VEC; key_end = 1;
        run_op(0, 12, 0, 0, lat, bcnt);
        check_eq("init_u1_latency", 320'(lat), 320'd13);
        check_eq("init_u1_busy", 320'(bcnt), 320'd12);
        check_eq("init_u1_state", st0, after_init);
        check_eq("init_u1_tag", tag0, after_init[127:0]);
        check_eq("init_u1_cipher", cip0, IV_128);
        @(negedge clock);
        check_eq("init_u1_done_pulse", done[0], 1'b0);

        // Same vector, UNROLL=2
        state_in = init128; key = K_VEC;
        run_op(1, 12, 0, 0, lat, bcnt);
        check_eq("init_u2_latency", 320'(lat), 320'd7);
        check_eq("init_u2_busy", 320'(bcnt), 320'd6);
        check_eq("init_u2_state", st1, after_init);

        // p^b with data absorb, constants start at 0x96
        state_in = after_init; data64 = 64'h0123456789ABCDEF; key_end = 0; data_begin = 1;
        entry3 = after_init;
        entry3[319:256] = entry3[319:256] ^ 64'h0123456789ABCDEF;
        want3 = m_perm(entry3, 6);
        run_op(0, 6, 0, 0, lat, bcnt);
        check_eq("pb6_latency", 320'(lat), 320'd7);
        check_eq("pb6_cipher", cip0, after_init[319:256] ^ 64'h0123456789ABCDEF);
        check_eq("pb6_state", st0, want3);

        // Ascon-128a, RATE=128, N=8, key into {x2,x3}
        data_begin = 0; key_begin = 1; key_end = 1; lsb_end = 1; key = K_VEC;
        state_in = {IV_128A, K_VEC, N_VEC};
        entry4 = state_in;
        entry4[191:64] = entry4[191:64] ^ K_VEC;
        want4 = m_perm(entry4, 8);
        want4[127:0] = want4[127:0] ^ K_VEC;
        want4[0] = ~want4[0];
        run_op(2, 8, 0, 0, lat, bcnt);
        check_eq("r128_latency", 320'(lat), 320'd5);
        check_eq("r128_state", st2, want4);
        check_eq("r128_tag", tag2, want4[127:0]);
        check_eq("r128_cipher", cip2, entry4[319:192]);

        // Illegal round count
        key_begin = 0; lsb_end = 0;
        @(negedge clock);
        num_rounds = 4'd5; start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        check_eq("err_pulse", err[0], 1'b1);
        check_eq("err_busy", busy[0], 1'b0);
        @(negedge clock);
        check_eq("err_pulse_end", {err[0], done[0], busy[0]}, 3'b000);
        check_eq("err_state_held", st0, want3);

        // Start during RUN is ignored
        state_in = init128; key = K_VEC; key_end = 1; lsb_end = 1;
        want6 = after_init;
        want6[0] = ~want6[0];
        run_op(1, 12, 0, 3, lat, bcnt);
        check_eq("restart_latency", 320'(lat), 320'd7);
        check_eq("restart_tag", tag1, want6[127:0]);
        repeat (3) @(negedge clock);
        check_eq("restart_no_second_done", {busy[1], done[1]}, 2'b00);

        // Stall for three cycles mid-run
        state_in = init128; key = K_VEC; lsb_end = 0;
        run_op(0, 12, 4, 0, lat, bcnt);
        check_eq("stall_latency", 320'(lat), 320'd16);
        check_eq("stall_state", st0, after_init);

        // Asynchronous reset mid-run
        state_in = init128; key = K_VEC;
        @(negedge clock);
        num_rounds = 4'd12; start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_outputs", {st0, tag0[63:0]}, 320'd0);
        check_eq("rst_cipher_flags", {cip0, busy[0], done[0], err[0]}, 320'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        done_seen = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clock);
            if (done[0] || busy[0]) done_seen++;
        end
        check_eq("rst_no_done", 320'(done_seen), 320'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
